// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable clock divider / clock-enable generator.
// A counter runs 0 .. period-1. The output is low for (period - high) cycles,
// then high for the remaining `high` cycles. A one-cycle tick marks the last
// cycle of each period. New period/high values arrive over a valid/ready
// handshake. They are clamped, held in a shadow, and applied only at a period
// boundary, or immediately while counting is disabled.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   en          count enable; counter, output and active config hold when 0
//   cfg_valid   configuration offered
//   cfg_ready   configuration can be accepted (low while one is pending)
//   cfg_period  requested period in clk cycles (clamped to >= 2)
//   cfg_high    requested high time in clk cycles (clamped to <= period)
//   div_out     divided output, registered
//   tick        registered pulse on the last cycle of each period
//   cfg_err     one-cycle pulse after an accepted configuration was clamped
//   cnt_out     current counter value
module clkdiv_prog #(
    parameter int unsigned WIDTH          = 28,
    parameter int unsigned DEFAULT_PERIOD = 100000000,
    parameter int unsigned DEFAULT_HIGH   = DEFAULT_PERIOD / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             div_out,
    output logic             tick,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cnt_out
);

    localparam logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DEF_HIGH   = WIDTH'(DEFAULT_HIGH);
    localparam logic [WIDTH-1:0] MIN_PERIOD = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    // At cnt = 0 the output is high only when the low phase is empty.
    localparam logic             DEF_DIV    = (DEFAULT_HIGH >= DEFAULT_PERIOD);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_sh_period;
    logic [WIDTH-1:0] r_sh_high;
    logic             r_div;
    logic             r_tick;
    logic             r_err;
    logic             r_ready;

    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_period_nx;
    logic [WIDTH-1:0] w_high_nx;
    logic [WIDTH-1:0] w_sh_period_nx;
    logic [WIDTH-1:0] w_sh_high_nx;
    logic [WIDTH-1:0] w_cl_period;
    logic [WIDTH-1:0] w_cl_high;
    logic             w_clamped;
    logic             w_xfer;
    logic             w_wrap;
    logic             w_div_nx;
    logic             w_tick_nx;
    logic             w_err_nx;
    logic             w_ready_nx;

    // Handshake decode and clamping of the offered configuration.
    always_comb begin
        w_xfer      = cfg_valid && (r_state == ST_RUN);
        w_cl_period = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
        w_cl_high   = (cfg_high > w_cl_period) ? w_cl_period : cfg_high;
        w_clamped   = (cfg_period < MIN_PERIOD) || (cfg_high > w_cl_period);
        w_wrap      = en && (r_cnt == (r_period - ONE));
    end

    // Next-state: counter, active/shadow configuration and control state.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_period_nx    = r_period;
        w_high_nx      = r_high;
        w_sh_period_nx = r_sh_period;
        w_sh_high_nx   = r_sh_high;

        case (r_state)
            ST_RUN: begin
                if (w_wrap && w_xfer) begin
                    // Offered on the boundary itself: apply without pending.
                    w_period_nx = w_cl_period;
                    w_high_nx   = w_cl_high;
                    w_cnt_nx    = '0;
                end else begin
                    if (en) begin
                        w_cnt_nx = w_wrap ? '0 : (r_cnt + ONE);
                    end
                    if (w_xfer) begin
                        w_sh_period_nx = w_cl_period;
                        w_sh_high_nx   = w_cl_high;
                        w_state_nx     = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                // Apply at the wrap, or at once while the counter is stopped.
                if (w_wrap || !en) begin
                    w_period_nx = r_sh_period;
                    w_high_nx   = r_sh_high;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_RUN;
                end else begin
                    w_cnt_nx = r_cnt + ONE;
                end
            end
            default: begin
                w_state_nx = ST_RUN;
            end
        endcase

        // Outputs are computed from next-state so they align with cnt_out.
        w_div_nx   = (w_cnt_nx >= (w_period_nx - w_high_nx));
        w_tick_nx  = en && (w_cnt_nx == (w_period_nx - ONE));
        w_err_nx   = w_xfer && w_clamped;
        w_ready_nx = (w_state_nx == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_period    <= DEF_PERIOD;
            r_high      <= DEF_HIGH;
            r_sh_period <= DEF_PERIOD;
            r_sh_high   <= DEF_HIGH;
            r_div       <= DEF_DIV;
            r_tick      <= 1'b0;
            r_err       <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_period    <= w_period_nx;
            r_high      <= w_high_nx;
            r_sh_period <= w_sh_period_nx;
            r_sh_high   <= w_sh_high_nx;
            r_div       <= w_div_nx;
            r_tick      <= w_tick_nx;
            r_err       <= w_err_nx;
            r_ready     <= w_ready_nx;
        end
    end

    assign cfg_ready = r_ready;
    assign div_out   = r_div;
    assign tick      = r_tick;
    assign cfg_err   = r_err;
    assign cnt_out   = r_cnt;

endmodule
